// File: rtl/mpu_cmd_buff.sv
// mpu_cmd_buff: microprocessor write-strobe to AXI4-Stream command buffer.
// Host writes WRITE_WIDTH words on an asynchronous strobe. The block packs
// them little-endian into DATA_WIDTH words and queues them in a FWFT FIFO
// that drives an AXIS master.

// One packing lane: holds a single WRITE_WIDTH slice of the word being built.
module mpu_cmd_buff_lane #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stb,     // captured write this cycle
  input  logic         sel,     // this lane is the current beat
  input  logic         clr,     // word completes this cycle, lane empties
  input  logic [W-1:0] din,
  output logic [W-1:0] lane_n   // lane value including this cycle's write
);

  logic [W-1:0] lane_q;

  // The completing write is bypassed into lane_n so the pushed word is whole.
  assign lane_n = (stb && sel) ? din : lane_q;

  // Lane storage; cleared after every push so unused upper lanes read zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          lane_q <= '0;
    else if (clr)        lane_q <= '0;
    else if (stb && sel) lane_q <= din;
  end

endmodule

module mpu_cmd_buff #(
  parameter int WRITE_WIDTH = 16,
  parameter int DATA_WIDTH  = 64,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_ena,
  input  logic [WRITE_WIDTH-1:0] data_in,
  input  logic                   wr_last,
  output logic                   ready,
  output logic                   overflow,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                   m_axis_tlast
);

  localparam int BEATS = DATA_WIDTH / WRITE_WIDTH;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);

  // ---------------------------------------------------------------------
  // Strobe synchronizer: one wr_stb per wr_ena rising edge.
  // ---------------------------------------------------------------------
  logic s1, s2, s3;
  logic wr_stb;

  // Three-flop chain; s3 is the previous s2 for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= wr_ena;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign wr_stb = s2 & ~s3;

  // ---------------------------------------------------------------------
  // Packer: beat counter plus per-lane registers.
  // data_in is held stable well before wr_ena rises, so it is sampled
  // directly on the strobe cycle without its own synchronizer.
  // ---------------------------------------------------------------------
  logic [CW-1:0]                         cnt;
  logic                                  last_beat;
  logic                                  push_n;
  logic [BEATS-1:0]                      lane_sel;
  logic [BEATS-1:0][WRITE_WIDTH-1:0]     word_n;

  assign last_beat = (cnt == CW'(BEATS - 1));
  assign push_n    = wr_stb & (last_beat | wr_last);

  // Beat counter: advance per write, restart at 0 when a word is pushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= '0;
    else if (wr_stb) cnt <= push_n ? '0 : cnt + CW'(1);
  end

  for (genvar g = 0; g < BEATS; g++) begin : g_lane
    assign lane_sel[g] = (cnt == CW'(g));
    mpu_cmd_buff_lane #(.W(WRITE_WIDTH)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .stb    (wr_stb),
      .sel    (lane_sel[g]),
      .clr    (push_n),
      .din    (data_in),
      .lane_n (word_n[g])
    );
  end

  // ---------------------------------------------------------------------
  // Push stage: completed word is registered, then written next edge.
  // ---------------------------------------------------------------------
  logic                  push_q;
  logic                  push_last;
  logic [DATA_WIDTH-1:0] push_data;

  // Stage the completed word and its frame marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_q    <= 1'b0;
      push_last <= 1'b0;
      push_data <= '0;
    end else begin
      push_q <= push_n;
      if (push_n) begin
        push_last <= wr_last;
        push_data <= word_n;
      end
    end
  end

  // ---------------------------------------------------------------------
  // FIFO: FWFT register array, pointers carry an extra wrap bit.
  // ---------------------------------------------------------------------
  logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
  logic [AW:0]         wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic                full, full_n;
  logic                pop, push_ok, drop;
  logic                tvalid_q, ready_q;
  logic [DATA_WIDTH:0] head;

  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop    = tvalid_q & m_axis_tready;
  // A simultaneous pop frees the head slot, so a push into a full FIFO is legal then.
  assign push_ok = push_q & (~full | pop);
  assign drop    = push_q & full & ~pop;

  assign wr_ptr_n = wr_ptr + {{AW{1'b0}}, push_ok};
  assign rd_ptr_n = rd_ptr + {{AW{1'b0}}, pop};
  assign full_n   = (wr_ptr_n[AW] != rd_ptr_n[AW]) &&
                    (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);

  // Storage array; contents are don't-care until covered by the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= {push_last, push_data};
  end

  // Pointers plus registered status flags derived from the next pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tvalid_q <= 1'b0;
      ready_q  <= 1'b1;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      tvalid_q <= (wr_ptr_n != rd_ptr_n);
      ready_q  <= ~full_n;
      if (drop) overflow <= 1'b1;
    end
  end

  // Head entry gated by valid so the bus reads zero while empty or in reset.
  assign head          = mem[rd_ptr[AW-1:0]];
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tvalid_q ? head[DATA_WIDTH-1:0] : '0;
  assign m_axis_tlast  = tvalid_q & head[DATA_WIDTH];
  assign ready         = ready_q;

endmodule
